tape_mode_select: RTL and testbench

Selects the tape load and save modes from two front-panel pushbuttons and holds them as the mode IDs shown on the 4-digit seven-segment display and used by the tape load/save engines. Each button input is synchronised, debounced and edge-detected; one accepted press steps its mode ID by one, with wrap-around. Presses are rejected while a tape transfer is running, so a mode cannot change mid-transfer.

---
 rtl/tape_mode_select.sv | 112 +++++++++++
 tb/tb_tape_mode_select.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tape_mode_select.sv
// Tape load/save mode selection from two front-panel pushbuttons.
// Each button is synchronised, debounced and edge-detected; accepted presses step a wrapping mode ID.

module tape_mode_debounce #(
   parameter int unsigned DEBOUNCE_CNT = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_n,
   output logic press_c
);

   localparam int unsigned CNT_W = (DEBOUNCE_CNT > 2) ? $clog2(DEBOUNCE_CNT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

   logic             sync1;
   logic             sync2;
   logic             stable;
   logic             stable_d;
   logic [CNT_W-1:0] cnt;

   // Synchroniser, debounce counter and delayed stable level for edge detection
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1    <= 1'b1;
         sync2    <= 1'b1;
         stable   <= 1'b1;
         stable_d <= 1'b1;
         cnt      <= '0;
      end else begin
         sync1    <= btn_n;
         sync2    <= sync1;
         stable_d <= stable;
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            stable <= sync2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // Press is the 1->0 transition of the stable level; releases are ignored
   assign press_c = stable_d & ~stable;

endmodule

module tape_mode_select #(
   parameter int unsigned DEBOUNCE_CNT = 568400,
   parameter int unsigned LOAD_MODES   = 2,
   parameter int unsigned SAVE_MODES   = 3
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_btn_load_n,
   input  logic       i_btn_save_n,
   input  logic       i_tape_busy,
   output logic [1:0] o_load_mode_id,
   output logic [1:0] o_save_mode_id,
   output logic       o_changed
);

   localparam logic [1:0] LOAD_LAST = 2'(LOAD_MODES - 1);
   localparam logic [1:0] SAVE_LAST = 2'(SAVE_MODES - 1);

   logic       load_press_c;
   logic       save_press_c;
   logic [1:0] load_next_c;
   logic [1:0] save_next_c;

   tape_mode_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_load_db (
      .clock   (i_clock),
      .reset   (i_reset),
      .btn_n   (i_btn_load_n),
      .press_c (load_press_c)
   );

   tape_mode_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_save_db (
      .clock   (i_clock),
      .reset   (i_reset),
      .btn_n   (i_btn_save_n),
      .press_c (save_press_c)
   );

   // Next mode IDs; presses seen while a transfer runs are dropped, not queued
   always_comb begin
      load_next_c = o_load_mode_id;
      save_next_c = o_save_mode_id;
      if (load_press_c && !i_tape_busy) begin
         load_next_c = (o_load_mode_id == LOAD_LAST) ? 2'd0 : 2'(o_load_mode_id + 2'd1);
      end
      if (save_press_c && !i_tape_busy) begin
         save_next_c = (o_save_mode_id == SAVE_LAST) ? 2'd0 : 2'(o_save_mode_id + 2'd1);
      end
   end

   // A single-mode channel never changes value, so it never pulses o_changed
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         o_load_mode_id <= 2'd0;
         o_save_mode_id <= 2'd0;
         o_changed      <= 1'b0;
      end else begin
         o_load_mode_id <= load_next_c;
         o_save_mode_id <= save_next_c;
         o_changed      <= (load_next_c != o_load_mode_id) || (save_next_c != o_save_mode_id);
      end
   end

endmodule

// File: tb/tb_tape_mode_select.sv
// Directed bench for tape_mode_select with DEBOUNCE_CNT=4, LOAD_MODES=2, SAVE_MODES=3.
// Expected IDs and pulse timing are hand-derived: a press sampled at edge 1 updates the ID at edge 7.

module tb_tape_mode_select;

   logic       clk;
   logic       rst;
   logic       btn_load_n;
   logic       btn_save_n;
   logic       busy;
   logic [1:0] load_id;
   logic [1:0] save_id;
   logic       changed;

   int total;
   int bad;

   tape_mode_select #(
      .DEBOUNCE_CNT(4),
      .LOAD_MODES  (2),
      .SAVE_MODES  (3)
   ) dut (
      .i_clock        (clk),
      .i_reset        (rst),
      .i_btn_load_n   (btn_load_n),
      .i_btn_save_n   (btn_save_n),
      .i_tape_busy    (busy),
      .o_load_mode_id (load_id),
      .o_save_mode_id (save_id),
      .o_changed      (changed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle before sampling or driving
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      btn_load_n = 1'b1;
      btn_save_n = 1'b1;
      busy = 1'b0;
      #2;
      tick();
      tick();
      total++;
      if (load_id !== 2'd0 || save_id !== 2'd0 || changed !== 1'b0) begin
         bad++;
         $display("FAIL reset_during: load=%0d save=%0d changed=%0b want 0/0/0", load_id, save_id, changed);
      end
      rst = 1'b0;
      repeat (8) tick();
      total++;
      if (load_id !== 2'd0 || save_id !== 2'd0 || changed !== 1'b0) begin
         bad++;
         $display("FAIL reset_after: load=%0d save=%0d changed=%0b want 0/0/0", load_id, save_id, changed);
      end
   endtask

   task automatic test_clean_save();
      logic [1:0] exp_seq [4];
      logic [1:0] prev;
      exp_seq = '{2'd1, 2'd2, 2'd0, 2'd1};
      prev = 2'd0;
      for (int k = 0; k < 4; k++) begin
         btn_save_n = 1'b0;
         for (int n = 1; n <= 10; n++) begin
            tick();
            if (n == 6) begin
               total++;
               if (save_id !== prev || changed !== 1'b0) begin
                  bad++;
                  $display("FAIL save_early_%0d: save=%0d changed=%0b want %0d/0", k, save_id, changed, prev);
               end
            end
            if (n == 7) begin
               total++;
               if (save_id !== exp_seq[k] || changed !== 1'b1) begin
                  bad++;
                  $display("FAIL save_step_%0d: save=%0d changed=%0b want %0d/1", k, save_id, changed, exp_seq[k]);
               end
            end
            if (n == 8) begin
               total++;
               if (changed !== 1'b0) begin
                  bad++;
                  $display("FAIL save_pulse_width_%0d: changed=%0b want 0", k, changed);
               end
            end
         end
         btn_save_n = 1'b1;
         repeat (10) tick();
         prev = exp_seq[k];
      end
      total++;
      if (load_id !== 2'd0) begin
         bad++;
         $display("FAIL save_load_untouched: load=%0d want 0", load_id);
      end
   endtask

   task automatic test_bounce();
      int pulses;
      logic [1:0] exp_seq [3];
      exp_seq = '{2'd0, 2'd1, 2'd0};
      pulses = 0;
      for (int k = 0; k < 5; k++) begin
         btn_load_n = 1'b0;
         repeat (3) begin
            tick();
            if (changed === 1'b1) pulses++;
         end
         btn_load_n = 1'b1;
         repeat (3) begin
            tick();
            if (changed === 1'b1) pulses++;
         end
      end
      repeat (6) begin
         tick();
         if (changed === 1'b1) pulses++;
      end
      total++;
      if (load_id !== 2'd0 || pulses != 0) begin
         bad++;
         $display("FAIL bounce_glitch: load=%0d pulses=%0d want 0/0", load_id, pulses);
      end
      btn_load_n = 1'b0;
      pulses = 0;
      for (int n = 1; n <= 10; n++) begin
         tick();
         if (changed === 1'b1) pulses++;
      end
      btn_load_n = 1'b1;
      repeat (10) tick();
      total++;
      if (load_id !== 2'd1 || pulses != 1) begin
         bad++;
         $display("FAIL bounce_hold: load=%0d pulses=%0d want 1/1", load_id, pulses);
      end
      for (int k = 0; k < 3; k++) begin
         btn_load_n = 1'b0;
         repeat (10) tick();
         btn_load_n = 1'b1;
         repeat (10) tick();
         total++;
         if (load_id !== exp_seq[k]) begin
            bad++;
            $display("FAIL load_clean_%0d: load=%0d want %0d", k, load_id, exp_seq[k]);
         end
      end
   endtask

   task automatic test_busy();
      int pulses;
      pulses = 0;
      busy = 1'b1;
      btn_save_n = 1'b0;
      repeat (20) begin
         tick();
         if (changed === 1'b1) pulses++;
      end
      total++;
      if (save_id !== 2'd1 || pulses != 0) begin
         bad++;
         $display("FAIL busy_locked: save=%0d pulses=%0d want 1/0", save_id, pulses);
      end
      busy = 1'b0;
      repeat (10) begin
         tick();
         if (changed === 1'b1) pulses++;
      end
      total++;
      if (save_id !== 2'd1 || pulses != 0) begin
         bad++;
         $display("FAIL busy_held_after: save=%0d pulses=%0d want 1/0", save_id, pulses);
      end
      btn_save_n = 1'b1;
      repeat (10) tick();
      btn_save_n = 1'b0;
      repeat (10) tick();
      btn_save_n = 1'b1;
      repeat (10) tick();
      total++;
      if (save_id !== 2'd2) begin
         bad++;
         $display("FAIL busy_repress: save=%0d want 2", save_id);
      end
   endtask

   task automatic test_simultaneous();
      btn_load_n = 1'b0;
      btn_save_n = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         tick();
         if (n == 6) begin
            total++;
            if (load_id !== 2'd0 || save_id !== 2'd2 || changed !== 1'b0) begin
               bad++;
               $display("FAIL simul_early: load=%0d save=%0d changed=%0b want 0/2/0", load_id, save_id, changed);
            end
         end
         if (n == 7) begin
            total++;
            if (load_id !== 2'd1 || save_id !== 2'd0 || changed !== 1'b1) begin
               bad++;
               $display("FAIL simul_step: load=%0d save=%0d changed=%0b want 1/0/1", load_id, save_id, changed);
            end
         end
         if (n == 8) begin
            total++;
            if (changed !== 1'b0) begin
               bad++;
               $display("FAIL simul_pulse_width: changed=%0b want 0", changed);
            end
         end
      end
      btn_load_n = 1'b1;
      btn_save_n = 1'b1;
      repeat (10) tick();
   endtask

   task automatic test_reset_mid_debounce();
      btn_load_n = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      #1;
      total++;
      if (load_id !== 2'd0 || save_id !== 2'd0 || changed !== 1'b0) begin
         bad++;
         $display("FAIL midreset_async: load=%0d save=%0d changed=%0b want 0/0/0", load_id, save_id, changed);
      end
      repeat (2) tick();
      rst = 1'b0;
      // Stable level flips at edge 6 after release; ID registers one edge later
      for (int n = 1; n <= 9; n++) begin
         tick();
         if (n == 6) begin
            total++;
            if (load_id !== 2'd0 || changed !== 1'b0) begin
               bad++;
               $display("FAIL midreset_early: load=%0d changed=%0b want 0/0", load_id, changed);
            end
         end
         if (n == 7) begin
            total++;
            if (load_id !== 2'd1 || save_id !== 2'd0 || changed !== 1'b1) begin
               bad++;
               $display("FAIL midreset_step: load=%0d save=%0d changed=%0b want 1/0/1", load_id, save_id, changed);
            end
         end
      end
      btn_load_n = 1'b1;
      repeat (10) tick();
   endtask

   initial begin
      total = 0;
      bad = 0;
      test_reset();
      test_clean_save();
      test_bounce();
      test_busy();
      test_simultaneous();
      test_reset_mid_debounce();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
